// File: rtl/ysyx_25020047_ifu_fetch_if.sv
// Fetch-stage bus: redirect input, imem request/response, decode output.
// master = fetch stage, slave = memory/decode/redirect side.
`timescale 1ns/1ps
interface ysyx_25020047_ifu_fetch_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_err;

  modport master (
    input  redirect_valid, redirect_pc,
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    output out_valid, out_inst, out_pc, out_err,
    input  out_ready
  );

  modport slave (
    output redirect_valid, redirect_pc,
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    input  out_valid, out_inst, out_pc, out_err,
    output out_ready
  );
endinterface

// File: rtl/ysyx_25020047_ifu_fetch.sv
// Instruction fetch: one-outstanding imem requests, output FIFO to decode.
// Ports: clk, rst (async active-low), bus (master: redirect/imem/out).
`timescale 1ns/1ps
module ysyx_25020047_ifu_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input logic                     clk,
  input logic                     rst,
  ysyx_25020047_ifu_fetch_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] L_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_REQ, S_WAIT, S_DROP, S_HALT
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [AW:0] r_count;
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [31:0] r_inst [FIFO_DEPTH];
  logic [31:0] r_ipc  [FIFO_DEPTH];
  logic        r_err  [FIFO_DEPTH];

  logic w_req_valid;
  logic w_hs;
  logic w_rsp;
  logic w_redir;
  logic w_push;
  logic w_pop;
  logic w_out_valid;

  assign w_redir = bus.redirect_valid;
  assign w_rsp   = bus.imem_rsp_valid;
  // rst gates the request so nothing leaves while in reset
  assign w_req_valid = rst & (r_state == S_REQ)
                     & (r_count < L_FULL);
  assign w_hs    = w_req_valid & bus.imem_req_ready;
  assign w_push  = (r_state == S_WAIT) & w_rsp & ~w_redir;
  assign w_out_valid = (r_count != '0);
  assign w_pop   = w_out_valid & bus.out_ready;

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_pc;
  assign bus.out_valid = w_out_valid;
  assign bus.out_inst  = r_inst[r_head];
  assign bus.out_pc    = r_ipc[r_head];
  assign bus.out_err   = r_err[r_head];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_REQ;
      r_pc    <= RESET_PC;
    end else if (w_redir) begin
      r_pc <= {bus.redirect_pc[31:2], 2'b00};
      // a request still in flight after this edge must be swallowed
      if (((r_state == S_WAIT) && !w_rsp) ||
          ((r_state == S_DROP) && !w_rsp) ||
          ((r_state == S_REQ) && w_hs))
        r_state <= S_DROP;
      else
        r_state <= S_REQ;
    end else begin
      unique case (r_state)
        S_REQ: begin
          if (w_hs) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_rsp) begin
            r_pc    <= r_pc + 32'd4;
            r_state <= bus.imem_rsp_err ? S_HALT : S_REQ;
          end
        end
        S_DROP: begin
          if (w_rsp) r_state <= S_REQ;
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_inst[i] <= '0;
        r_ipc[i]  <= '0;
        r_err[i]  <= 1'b0;
      end
    end else if (w_redir) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_inst[r_tail] <= bus.imem_rsp_data;
        r_ipc[r_tail]  <= r_pc;
        r_err[r_tail]  <= bus.imem_rsp_err;
        r_tail <= r_tail + 1'b1;
      end
      if (w_pop) r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_25020047_ifu_fetch.sv
// Randomized scoreboard bench for the fetch stage.
// Expected fetch stream is derived from redirect targets and memory contents.
`timescale 1ns/1ps
module tb_ysyx_25020047_ifu_fetch;
  localparam logic [31:0] RPC = 32'h8000_0000;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  ysyx_25020047_ifu_fetch_if bus();

  ysyx_25020047_ifu_fetch #(
    .RESET_PC(RPC),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  logic [31:0] err_addr;
  int ready_pct, lat_min, lat_max;
  bit want_redir;
  int redir_mode, redir_age;
  logic [31:0] redir_tgt, cur_tgt;
  int rsp_count = 0;
  bit saw_zero = 0;

  int consumed = 0;
  logic [31:0] last_pc;
  logic last_err = 0;

  task automatic chk(input bit ok, input string nm,
                     input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %08h want %08h at %0t", nm, act, req, $time);
    end
  endtask

  // Expected stream after a (re)start: sequential words until the first fault.
  task automatic rebuild(input logic [31:0] t);
    logic [31:0] p;
    exp_t e;
    q.delete();
    p = t;
    for (int i = 0; i < 512; i++) begin
      e.pc = p;
      e.inst = p ^ 32'h13;
      e.err = (p == err_addr);
      q.push_back(e);
      if (e.err) break;
      p = p + 32'd4;
    end
  endtask

  // Memory + redirect driver
  bit pend = 0, hs_cap, go;
  logic [31:0] paddr, addr_cap;
  int wc;
  initial begin
    bus.redirect_valid = 0;
    bus.redirect_pc = 0;
    bus.imem_req_ready = 0;
    bus.imem_rsp_valid = 0;
    bus.imem_rsp_data = 0;
    bus.imem_rsp_err = 0;
    forever begin
      @(negedge clk);
      hs_cap = rst && bus.imem_req_valid && bus.imem_req_ready;
      addr_cap = bus.imem_req_addr;
      @(posedge clk);
      #1;
      if (!rst) begin
        pend = 0;
        bus.imem_rsp_valid = 0;
        bus.imem_req_ready = 0;
        bus.redirect_valid = 0;
      end else begin
        if (bus.redirect_valid) rebuild(cur_tgt);
        bus.redirect_valid = 0;
        bus.imem_rsp_valid = 0;
        bus.imem_rsp_data = 0;
        bus.imem_rsp_err = 0;
        if (hs_cap) begin
          chk(!pend, "one_outstanding", addr_cap, paddr);
          pend = 1;
          paddr = addr_cap;
          wc = $urandom_range(lat_max, lat_min);
          if (addr_cap == 32'h0) saw_zero = 1;
        end
        if (pend) begin
          if (wc == 0) begin
            bus.imem_rsp_valid = 1;
            bus.imem_rsp_data = paddr ^ 32'h13;
            bus.imem_rsp_err = (paddr == err_addr);
            pend = 0;
            rsp_count++;
          end else begin
            wc--;
          end
        end
        bus.imem_req_ready = ($urandom_range(0, 99) < ready_pct);
        if (want_redir) begin
          redir_age++;
          case (redir_mode)
            0: go = 1;
            1: go = bus.imem_rsp_valid;
            2: go = bus.imem_req_valid;
            default: go = pend;
          endcase
          if (redir_age > 40) go = 1;
          if (go) begin
            bus.redirect_valid = 1;
            bus.redirect_pc = redir_tgt | 32'($urandom_range(0, 3));
            cur_tgt = redir_tgt;
            if (redir_mode == 2) bus.imem_req_ready = 1;
            want_redir = 0;
          end
        end
      end
    end
  end

  // Monitor
  exp_t e;
  bit p_pend = 0, p_redir = 0, halted = 0;
  logic [31:0] p_addr;
  always @(negedge clk) begin
    if (!rst) begin
      chk(!bus.out_valid, "rst_out_valid", 32'(bus.out_valid), 0);
      chk(bus.out_inst == 0, "rst_out_inst", bus.out_inst, 0);
      chk(bus.out_pc == 0, "rst_out_pc", bus.out_pc, 0);
      chk(!bus.out_err, "rst_out_err", 32'(bus.out_err), 0);
      chk(!bus.imem_req_valid, "rst_req_valid", 32'(bus.imem_req_valid), 0);
      p_pend = 0;
      p_redir = 0;
      halted = 0;
    end else begin
      if (p_redir)
        chk(!bus.out_valid, "flush_valid", 32'(bus.out_valid), 0);
      if (p_pend)
        chk(bus.imem_req_valid && bus.imem_req_addr == p_addr,
            "addr_stable", bus.imem_req_addr, p_addr);
      if (halted)
        chk(!bus.imem_req_valid, "halt_no_req", 32'(bus.imem_req_valid), 0);
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          chk(0, "unexpected_out", bus.out_pc, 0);
        end else begin
          e = q.pop_front();
          chk(bus.out_pc == e.pc, "out_pc", bus.out_pc, e.pc);
          chk(bus.out_inst == e.inst, "out_inst", bus.out_inst, e.inst);
          chk(bus.out_err == e.err, "out_err", 32'(bus.out_err), 32'(e.err));
          if (e.err) halted = 1;
        end
        consumed++;
        last_pc = bus.out_pc;
        last_err = bus.out_err;
      end
      if (bus.redirect_valid) halted = 0;
      p_pend = bus.imem_req_valid && !bus.imem_req_ready && !bus.redirect_valid;
      p_addr = bus.imem_req_addr;
      p_redir = bus.redirect_valid;
    end
  end

  task automatic do_redirect(input int mode, input logic [31:0] t);
    int n;
    redir_mode = mode;
    redir_tgt = t;
    redir_age = 0;
    want_redir = 1;
    n = 0;
    while (want_redir && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(!want_redir, "redirect_issued", t, t);
    want_redir = 0;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, n;
    bit found;
    ready_pct = 100;
    lat_min = 0;
    lat_max = 0;
    err_addr = 32'h1;
    want_redir = 0;
    redir_mode = 0;
    redir_age = 0;
    redir_tgt = 0;
    cur_tgt = RPC;
    bus.out_ready = 0;
    rebuild(RPC);
    repeat (3) @(posedge clk);
    #1;
    rst = 1;
    bus.out_ready = 1;
    @(negedge clk);
    chk(bus.imem_req_valid, "first_req_valid", 32'(bus.imem_req_valid), 1);
    chk(bus.imem_req_addr == RPC, "first_req_addr", bus.imem_req_addr, RPC);
    repeat (30) @(negedge clk);
    chk(consumed >= 10, "stream_progress", consumed, 10);

    @(posedge clk);
    #1 bus.out_ready = 0;
    repeat (10) @(negedge clk);
    chk(rsp_count - consumed == DEPTH, "buffered", rsp_count - consumed, DEPTH);
    chk(!bus.imem_req_valid, "full_no_req", 32'(bus.imem_req_valid), 0);
    chk(bus.out_valid, "full_out_valid", 32'(bus.out_valid), 1);
    c0 = consumed;
    @(posedge clk);
    #1 bus.out_ready = 1;
    repeat (20) @(negedge clk);
    chk(consumed - c0 >= DEPTH + 2, "drain", consumed - c0, DEPTH + 2);

    lat_min = 2;
    lat_max = 2;
    do_redirect(3, 32'h8000_0100);
    found = 0;
    n = 0;
    while (!found && n < 20) begin
      @(negedge clk);
      n++;
      if (bus.imem_req_valid) found = 1;
    end
    chk(found && bus.imem_req_addr == 32'h8000_0100, "redir_req_addr",
        bus.imem_req_addr, 32'h8000_0100);
    c0 = consumed;
    repeat (20) @(negedge clk);
    chk(consumed > c0, "redir_progress", consumed, c0 + 1);

    lat_min = 0;
    lat_max = 2;
    do_redirect(1, 32'h8000_0200);
    repeat (20) @(negedge clk);
    do_redirect(2, 32'h8000_0300);
    repeat (20) @(negedge clk);

    err_addr = 32'h8000_0008;
    lat_max = 1;
    last_err = 0;
    do_redirect(0, 32'h8000_0000);
    n = 0;
    while (!last_err && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(last_err, "fault_seen", 32'(last_err), 1);
    chk(last_pc == 32'h8000_0008, "fault_pc", last_pc, 32'h8000_0008);
    c0 = consumed;
    repeat (20) @(negedge clk);
    chk(consumed == c0, "halt_no_out", consumed, c0);
    err_addr = 32'h1;
    do_redirect(0, 32'h8000_0400);
    repeat (20) @(negedge clk);
    chk(consumed > c0, "resume", consumed, c0 + 1);

    saw_zero = 0;
    do_redirect(0, 32'hFFFF_FFF8);
    repeat (20) @(negedge clk);
    chk(saw_zero, "wrap_req_zero", 32'(saw_zero), 1);

    ready_pct = 70;
    lat_min = 0;
    lat_max = 3;
    err_addr = 32'h8000_0040;
    c0 = consumed;
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk);
      #1;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (!want_redir && $urandom_range(0, 49) == 0) begin
        redir_mode = $urandom_range(0, 3);
        if ($urandom_range(0, 9) == 0)
          redir_tgt = 32'hFFFF_FFF0;
        else
          redir_tgt = 32'h8000_0000 + 32'($urandom_range(0, 255)) * 32'd4;
        redir_age = 0;
        want_redir = 1;
      end
    end
    bus.out_ready = 1;
    repeat (10) @(negedge clk);
    chk(consumed > c0 + 100, "random_progress", consumed - c0, 101);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ysyx_25020047_ifu_fetch.md
Name: ysyx_25020047_ifu_fetch

Overview:
Instruction fetch stage, directly upstream of the decode stage. Owns the fetch PC and issues one-outstanding requests to a variable-latency instruction memory. Buffers returned words with their PCs in a small FIFO and presents them to decode over a valid/ready handshake. Accepts redirects (branch/jump target from the dnpc path), which flush all in-flight and buffered fetches.

Parameters:
RESET_PC, 32'h8000_0000, fetch PC loaded at reset.
FIFO_DEPTH, 2, output buffer entries (power of two, >=2).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset; asynchronous, active-low.
redirect_valid  in  1  replace fetch PC this cycle.
redirect_pc  in  32  new fetch PC; bits[1:0] ignored and treated as 0.
imem_req_valid  out  1  fetch request.
imem_req_ready  in  1  memory accepts request.
imem_req_addr  out  32  word-aligned fetch address.
imem_rsp_valid  in  1  response strobe, one per accepted request, latency >=1 cycle.
imem_rsp_data  in  32  fetched instruction.
imem_rsp_err  in  1  access fault.
out_valid  out  1  head entry valid to decode.
out_ready  in  1  decode consumes head.
out_inst  out  32  instruction.
out_pc  out  32  PC of out_inst.
out_err  out  1  entry carries a fetch fault.

Behaviour:
- Reset (rst=0, async): fetch_pc=RESET_PC, state=REQ, FIFO empty, count=0, storage zeroed. imem_req_valid=0 while rst=0. out_valid=0, out_inst=0, out_pc=0, out_err=0. First request goes out in the first cycle after release.
- Request handshake: transfer when imem_req_valid & imem_req_ready. imem_req_addr=fetch_pc.
- Address stability: addr holds stable while valid and not accepted. The only exception is a redirect.
- At most one outstanding request.
- States:
  - REQ: req_valid=1 only if count<FIFO_DEPTH. On handshake go to WAIT.
  - WAIT: req_valid=0. On rsp_valid, push {rsp_data, fetch_pc, rsp_err} and set fetch_pc+=4 (mod 2^32, wraps 32'hFFFF_FFFC->0). If rsp_err, go to HALT; else go to REQ.
  - DROP: req_valid=0. On rsp_valid, discard the response and go to REQ.
  - HALT: req_valid=0. Stay until redirect.
- Redirect (highest priority, any state):
  - fetch_pc<=redirect_pc and FIFO flushed (count=0) in the same edge.
  - Next state: DROP if a request is outstanding after this edge (WAIT without rsp this cycle, or REQ with handshake this cycle). Otherwise REQ.
  - A response arriving in the redirect cycle is discarded, never pushed.
  - out_valid=0 the cycle after a redirect.
- FIFO:
  - out_valid=(count!=0); out_* driven from head registers.
  - Pop on out_valid & out_ready.
  - Push and pop in the same cycle keep count unchanged.
  - Overflow is impossible because a request is issued only with count<FIFO_DEPTH, and count cannot grow while waiting.
  - A pop in the redirect cycle is accepted by decode; flush still clears the remaining entries.
- Latency: response at edge N makes out_valid=1 after edge N (registered), provided the FIFO was empty. Best-case throughput is one instruction per 2 cycles with 1-cycle memory.
- Reset asserted mid-transaction: state and FIFO cleared immediately. Memory must also be reset, because the pending response is not tracked.

Test Plan:
- Reset release, memory always ready, 1-cycle latency, data=PC^32'h13 -> requests 0x8000_0000, 0x8000_0004, 0x8000_0008...; out_pc/out_inst pairs match; every output is 0 during reset.
- out_ready=0 for 10 cycles -> exactly FIFO_DEPTH entries buffered and req_valid=0. Then out_ready=1 -> entries drain in order with no loss or duplication.
- Redirect to 0x8000_0100 while WAIT, response arriving 2 cycles later -> response dropped. Next request addr=0x8000_0100; first out_pc=0x8000_0100.
- Redirect in the same cycle as rsp_valid, and separately in the same cycle as the req handshake -> neither the stale response nor the old-address response is ever output.
- rsp_err=1 at 0x8000_0008 -> entry out_err=1, out_pc=0x8000_0008; no further requests until redirect, then fetch resumes from redirect_pc.
- fetch_pc 0xFFFF_FFFC -> next request addr 0x0000_0000.
